// File: rtl/sample_stream_port.sv
// Sample I/O responder for the controller's active-low new_in / new_out requests.
// Buffers input samples for the data-RAM write path and rounds/saturates MAC results onto the output stream.
//
// Input request FSM:
//   state | meaning
//   IDLE  | no input request outstanding
//   WAIT  | request seen on an empty FIFO; stall raised, timeout running
module sample_stream_port #(
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 40,
  parameter int SHIFT     = 15,
  parameter int IN_DEPTH  = 8,
  parameter int OUT_DEPTH = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [DATA_W-1:0]          s_in_data,
  input  logic                       s_in_valid,
  output logic                       s_in_ready,
  input  logic                       new_in,
  output logic [DATA_W-1:0]          smp_data,
  output logic                       smp_valid,
  output logic                       stall,
  input  logic                       new_out,
  input  logic [ACC_W-1:0]           mac_res,
  output logic [DATA_W-1:0]          m_out_data,
  output logic                       m_out_valid,
  input  logic                       m_out_ready,
  output logic [$clog2(IN_DEPTH):0]  in_level,
  output logic [$clog2(OUT_DEPTH):0] out_level,
  output logic                       err_underflow,
  output logic                       err_overflow,
  input  logic                       clr_err
);

  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int OUT_AW = $clog2(OUT_DEPTH);
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SH1    = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [ACC_W:0] RND = (SHIFT > 0) ? ((ACC_W+1)'(1) << SH1) : '0;
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic {IDLE, WAIT} in_state_t;

  in_state_t state, state_nxt;

  logic new_in_q, new_out_q;
  logic req_in, req_out;

  logic [DATA_W-1:0] in_mem [IN_DEPTH];
  logic [IN_AW-1:0]  in_wr, in_rd;
  logic [IN_AW:0]    in_cnt;
  logic              in_full, in_empty, in_push, in_pop;

  logic [DATA_W-1:0] out_mem [OUT_DEPTH];
  logic [OUT_AW-1:0] out_wr, out_rd;
  logic [OUT_AW:0]   out_cnt;
  logic              out_full, out_empty, out_push, out_pop, out_drop;

  logic [CNT_W-1:0]  wait_cnt;
  logic              load_cnt, serve, time_out;

  logic signed [ACC_W:0] sum, shifted;
  logic [DATA_W-1:0]     sat;

  // Requests are falling edges; the edge registers follow the pins even with en low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      new_in_q  <= 1'b1;
      new_out_q <= 1'b1;
    end else begin
      new_in_q  <= new_in;
      new_out_q <= new_out;
    end
  end

  assign req_in  = !new_in  && new_in_q  && en;
  assign req_out = !new_out && new_out_q && en;

  assign in_full    = (in_cnt == (IN_AW+1)'(IN_DEPTH));
  assign in_empty   = (in_cnt == '0);
  assign s_in_ready = rst && !in_full;
  assign in_push    = s_in_valid && s_in_ready;
  assign in_level   = in_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_wr  <= '0;
      in_rd  <= '0;
      in_cnt <= '0;
    end else begin
      if (in_push) in_wr <= in_wr + 1'b1;
      if (in_pop)  in_rd <= in_rd + 1'b1;
      case ({in_push, in_pop})
        2'b10:   in_cnt <= in_cnt + 1'b1;
        2'b01:   in_cnt <= in_cnt - 1'b1;
        default: in_cnt <= in_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr] <= s_in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_pop    = 1'b0;
    serve     = 1'b0;
    time_out  = 1'b0;
    load_cnt  = 1'b0;
    case (state)
      IDLE: begin
        if (req_in) begin
          if (!in_empty) begin
            in_pop = 1'b1;
            serve  = 1'b1;
          end else begin
            state_nxt = WAIT;
            load_cnt  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!in_empty) begin
          in_pop    = 1'b1;
          serve     = 1'b1;
          state_nxt = IDLE;
        end else if (wait_cnt == '0) begin
          time_out  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall = (state == WAIT);

  // Down-counter: loaded on WAIT entry, terminal count at zero gives TIMEOUT wait cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt      <= '0;
      smp_data      <= '0;
      smp_valid     <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (load_cnt)                            wait_cnt <= CNT_W'(TIMEOUT - 1);
      else if (state == WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
      smp_valid <= serve || time_out;
      if (serve)         smp_data <= in_mem[in_rd];
      else if (time_out) smp_data <= '0;
      if (time_out)     err_underflow <= 1'b1;
      else if (clr_err) err_underflow <= 1'b0;
    end
  end

  assign sum     = $signed({mac_res[ACC_W-1], mac_res}) + $signed(RND);
  assign shifted = sum >>> SHIFT;

  always_comb begin
    sat = shifted[DATA_W-1:0];
    if (shifted > SAT_MAX)      sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (shifted < SAT_MIN) sat = {1'b1, {(DATA_W-1){1'b0}}};
  end

  assign out_full    = (out_cnt == (OUT_AW+1)'(OUT_DEPTH));
  assign out_empty   = (out_cnt == '0);
  assign m_out_valid = !out_empty;
  assign out_pop     = m_out_valid && m_out_ready;
  assign out_push    = req_out && (!out_full || out_pop);
  assign out_drop    = req_out && out_full && !out_pop;
  assign out_level   = out_cnt;
  assign m_out_data  = out_empty ? '0 : out_mem[out_rd];

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_wr       <= '0;
      out_rd       <= '0;
      out_cnt      <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (out_push) out_wr <= out_wr + 1'b1;
      if (out_pop)  out_rd <= out_rd + 1'b1;
      case ({out_push, out_pop})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
      if (out_drop)     err_overflow <= 1'b1;
      else if (clr_err) err_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (out_push) out_mem[out_wr] <= sat;
  end

endmodule

// File: tb/tb_sample_stream_port.sv
// Directed bench for sample_stream_port: expected samples are queued at stimulus time
// and a negedge monitor pops and compares them whenever the DUT presents a sample.
module tb_sample_stream_port;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [15:0] s_in_data;
  logic        s_in_valid, s_in_ready;
  logic        new_in;
  logic [15:0] smp_data;
  logic        smp_valid, stall;
  logic        new_out;
  logic [39:0] mac_res;
  logic [15:0] m_out_data;
  logic        m_out_valid, m_out_ready;
  logic [3:0]  in_level, out_level;
  logic        err_underflow, err_overflow, clr_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_smp [$];
  logic [15:0] exp_out [$];

  logic [39:0] mac_v [7];
  logic [15:0] res_v [7];

  sample_stream_port dut (
    .clk(clk), .rst(rst), .en(en),
    .s_in_data(s_in_data), .s_in_valid(s_in_valid), .s_in_ready(s_in_ready),
    .new_in(new_in), .smp_data(smp_data), .smp_valid(smp_valid), .stall(stall),
    .new_out(new_out), .mac_res(mac_res),
    .m_out_data(m_out_data), .m_out_valid(m_out_valid), .m_out_ready(m_out_ready),
    .in_level(in_level), .out_level(out_level),
    .err_underflow(err_underflow), .err_overflow(err_overflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_in(input logic [15:0] d);
    s_in_data  = d;
    s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
  endtask

  // Leaves the bench just after the edge that registered the request.
  task automatic in_req();
    new_in = 1'b0;
    tick();
    new_in = 1'b1;
  endtask

  task automatic out_req(input logic [39:0] m);
    new_out = 1'b0;
    mac_res = m;
    tick();
    new_out = 1'b1;
    tick();
  endtask

  task automatic drain_out();
    int n;
    n = 0;
    m_out_ready = 1'b1;
    while (out_level != 0 && n < 50) begin
      tick();
      n++;
    end
    m_out_ready = 1'b0;
    chk("out_drained", out_level, 0);
  endtask

  always @(negedge clk) begin
    if (smp_valid) begin
      if (exp_smp.size() == 0) chk("smp_unexpected", 1, 0);
      else                     chk("smp_data", smp_data, exp_smp.pop_front());
    end
    if (m_out_valid && m_out_ready) begin
      if (exp_out.size() == 0) chk("out_unexpected", 1, 0);
      else                     chk("m_out_data", m_out_data, exp_out.pop_front());
    end
  end

  initial begin
    int n, pulses;
    mac_v = '{40'h00_0000_4000, 40'h7F_FFFF_FFFF, 40'h80_0000_0000, 40'hFF_FFFF_BFFF,
              40'h00_0000_C000, 40'h00_3FFF_8000, 40'h00_3FFF_C000};
    res_v = '{16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0002, 16'h7FFF, 16'h7FFF};
    rst = 1'b0; en = 1'b1; s_in_data = '0; s_in_valid = 1'b0; new_in = 1'b1;
    new_out = 1'b1; mac_res = '0; m_out_ready = 1'b0; clr_err = 1'b0;
    tick(); tick();
    chk("rst_in_level", in_level, 0);
    chk("rst_out_level", out_level, 0);
    chk("rst_smp_valid", smp_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_errs", {err_underflow, err_overflow}, 0);
    chk("rst_s_in_ready", s_in_ready, 0);
    chk("rst_m_out_valid", m_out_valid, 0);
    rst = 1'b1;
    tick();
    chk("ready_after_rst", s_in_ready, 1);

    push_in(16'h0011); push_in(16'h0022); push_in(16'h0033);
    chk("in_level_3", in_level, 3);
    chk("s_in_ready_3", s_in_ready, 1);
    exp_smp.push_back(16'h0011); exp_smp.push_back(16'h0022); exp_smp.push_back(16'h0033);
    for (int i = 0; i < 3; i++) begin
      in_req();
      chk("smp_latency1", smp_valid, 1);
      tick();
    end
    chk("in_level_0", in_level, 0);

    in_req();
    chk("stall_on_empty", stall, 1);
    chk("no_smp_on_empty", smp_valid, 0);
    tick(); tick(); tick(); tick();
    chk("stall_held", stall, 1);
    exp_smp.push_back(16'h1234);
    push_in(16'h1234);
    tick();
    chk("wait_served", smp_valid, 1);
    chk("wait_data", smp_data, 16'h1234);
    chk("wait_stall_clr", stall, 0);
    chk("no_underflow", err_underflow, 0);
    tick();

    exp_smp.push_back(16'h0000);
    in_req();
    n = 0;
    while (!smp_valid && n < 100) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, 64);
    chk("underflow_set", err_underflow, 1);
    chk("timeout_stall_clr", stall, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("underflow_clr", err_underflow, 0);

    for (int i = 0; i < 7; i++) begin
      exp_out.push_back(res_v[i]);
      out_req(mac_v[i]);
    end
    chk("out_level_7", out_level, 7);
    drain_out();

    for (int k = 1; k <= 8; k++) begin
      exp_out.push_back(16'(k));
      out_req(40'(k) << 15);
    end
    chk("out_full", out_level, 8);
    chk("no_overflow_yet", err_overflow, 0);
    out_req(40'd99 << 15);
    chk("drop_level", out_level, 8);
    chk("overflow_set", err_overflow, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("overflow_clr", err_overflow, 0);
    exp_out.push_back(16'd9);
    new_out = 1'b0; mac_res = 40'd9 << 15; m_out_ready = 1'b1;
    tick();
    new_out = 1'b1; m_out_ready = 1'b0;
    chk("full_push_pop_level", out_level, 8);
    chk("full_push_pop_noerr", err_overflow, 0);
    drain_out();

    push_in(16'h0AAA); push_in(16'h0BBB);
    exp_smp.push_back(16'h0AAA);
    new_in = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (smp_valid) pulses++;
    end
    new_in = 1'b1;
    tick();
    chk("held_low_once", pulses, 1);
    chk("held_low_level", in_level, 1);
    en = 1'b0;
    new_in = 1'b0;
    tick();
    chk("en_low_no_pop", smp_valid, 0);
    new_in = 1'b1;
    tick();
    en = 1'b1;
    tick();
    chk("en_low_level", in_level, 1);

    exp_smp.push_back(16'h0BBB);
    in_req();
    tick();
    for (int k = 1; k <= 4; k++) begin
      exp_out.push_back(16'(k));
      out_req(40'(k) << 15);
    end
    in_req();
    chk("pre_rst_stall", stall, 1);
    chk("pre_rst_out_level", out_level, 4);
    rst = 1'b0;
    tick();
    exp_out.delete();
    chk("mid_rst_levels", {in_level, out_level}, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_smp", {smp_valid, smp_data}, 0);
    chk("mid_rst_out", {m_out_valid, m_out_data}, 0);
    chk("mid_rst_errs", {err_underflow, err_overflow}, 0);
    rst = 1'b1;
    tick(); tick();
    chk("post_rst_stall", stall, 0);
    chk("smp_queue_empty", exp_smp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
